// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the BCD display scanner: segment patterns
// (active low, {g,f,e,d,c,b,a}), digit indices and FSM state encoding.
package bcd_disp_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] dig_idx_t;

    localparam seg_t SEG_0    = 7'h40;
    localparam seg_t SEG_1    = 7'h79;
    localparam seg_t SEG_2    = 7'h24;
    localparam seg_t SEG_3    = 7'h30;
    localparam seg_t SEG_4    = 7'h19;
    localparam seg_t SEG_5    = 7'h12;
    localparam seg_t SEG_6    = 7'h02;
    localparam seg_t SEG_7    = 7'h78;
    localparam seg_t SEG_8    = 7'h00;
    localparam seg_t SEG_9    = 7'h10;
    localparam seg_t SEG_DASH = 7'h3F;
    localparam seg_t SEG_OFF  = 7'h7F;

    localparam dig_idx_t DIG_ONES = 2'd0;
    localparam dig_idx_t DIG_TENS = 2'd1;
    localparam dig_idx_t DIG_HUNS = 2'd2;

    localparam logic [0:0] GUARD = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    // Active-low anode pattern for one lit digit.
    function automatic logic [2:0] anode_sel(input dig_idx_t idx);
        case (idx)
            DIG_ONES: anode_sel = 3'b110;
            DIG_TENS: anode_sel = 3'b101;
            DIG_HUNS: anode_sel = 3'b011;
            default:  anode_sel = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Bus between the BCD source and the display scanner.
// Handshake: load is a one-cycle qualifier for bcd_in with no ready/back-pressure;
// the scanner always accepts it. Display outputs are free-running registers, and
// frame_o marks the first cycle of each scan frame. dbg_state mirrors the FSM state.
interface bcd_display_scan_if;
    logic [11:0] bcd_in;
    logic        load;
    logic [2:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_o;
    logic [0:0]  dbg_state;

    modport master (output bcd_in, output load,
                    input an_n, input seg_n, input frame_o, input dbg_state);
    modport slave  (input bcd_in, input load,
                    output an_n, output seg_n, output frame_o, output dbg_state);
endinterface

// File: rtl/bcd_display_scan_seg_decode.sv
// Combinational BCD nibble to active-low 7-segment decode; A-F shows a dash.
module bcd_seg_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Table lookup, non-decimal nibbles fall through to the dash.
    always_comb begin
        case (nibble)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// 3-digit multiplexed 7-segment scanner with frame-synchronous value commit
// and an all-off guard interval at the start of every digit slot.
// Optional feature: define BCD_SCAN_LZB_EN for leading-zero blanking.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_display_scan_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    dig_idx_t         idx, idx_nxt;
    logic [0:0]       state, state_nxt;
    logic             running;
    logic             frame_start;
    logic [11:0]      display, display_nxt;
    logic [11:0]      shadow, shadow_nxt;
    logic             pending, pending_nxt;
    logic [3:0]       nibble;
    logic             blank;
    logic [6:0]       dec_seg;
    logic [2:0]       an_r;
    logic [6:0]       seg_r;
    logic             frame_r;

    // Next slot position; the first edge after reset opens frame 0 without advancing.
    always_comb begin
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        frame_start = 1'b0;
        if (!running) begin
            cnt_nxt     = '0;
            idx_nxt     = DIG_ONES;
            frame_start = 1'b1;
        end else if (cnt == CNT_MAX) begin
            cnt_nxt     = '0;
            idx_nxt     = (idx == DIG_HUNS) ? DIG_ONES : dig_idx_t'(idx + 2'd1);
            frame_start = (idx == DIG_HUNS);
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        state_nxt = (int'(cnt_nxt) < GUARD_CYCLES) ? GUARD : SHOW;
    end

    // Shadow capture and frame-boundary commit; a load on the boundary bypasses the shadow.
    always_comb begin
        display_nxt = display;
        shadow_nxt  = shadow;
        pending_nxt = pending;
        if (frame_start) begin
            if (bus.load) begin
                display_nxt = bus.bcd_in;
                shadow_nxt  = bus.bcd_in;
            end else if (pending) begin
                display_nxt = shadow;
            end
            pending_nxt = 1'b0;
        end else if (bus.load) begin
            shadow_nxt  = bus.bcd_in;
            pending_nxt = 1'b1;
        end
    end

    // Select the digit that will be on the display after this edge.
    always_comb begin
        case (idx_nxt)
            DIG_TENS: nibble = display_nxt[7:4];
            DIG_HUNS: nibble = display_nxt[11:8];
            default:  nibble = display_nxt[3:0];
        endcase
`ifdef BCD_SCAN_LZB_EN
        blank = ((idx_nxt == DIG_HUNS) && (display_nxt[11:8] == 4'd0)) ||
                ((idx_nxt == DIG_TENS) && (display_nxt[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif
    end

    bcd_seg_decode u_dec (
        .nibble (nibble),
        .seg_n  (dec_seg)
    );

    // State, counters, value registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= DIG_ONES;
            state   <= GUARD;
            running <= 1'b0;
            display <= 12'h000;
            shadow  <= 12'h000;
            pending <= 1'b0;
            an_r    <= 3'b111;
            seg_r   <= SEG_OFF;
            frame_r <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            state   <= state_nxt;
            running <= 1'b1;
            display <= display_nxt;
            shadow  <= shadow_nxt;
            pending <= pending_nxt;
            an_r    <= (state_nxt == SHOW) ? anode_sel(idx_nxt) : 3'b111;
            seg_r   <= ((state_nxt == SHOW) && !blank) ? dec_seg : SEG_OFF;
            frame_r <= frame_start;
        end
    end

    assign bus.an_n      = an_r;
    assign bus.seg_n     = seg_r;
    assign bus.frame_o   = frame_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan with REFRESH_DIV=4, GUARD_CYCLES=1.
// Each driven cycle pushes the expected {frame_o, an_n, seg_n} produced by a
// position-based display model; a monitor pops and compares after every edge.
module tb_bcd_display_scan;

    localparam int RD    = 4;
    localparam int GC    = 1;
    localparam int FRAME = 3 * RD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_display_scan_if bus ();

    bcd_display_scan #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [10:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Time is the number of cycles since reset release; a frame is FRAME cycles.
    bit          m_in_reset = 1'b1;
    int          m_p        = 0;
    logic [11:0] m_shown    = 12'h000;
    logic [11:0] m_latest   = 12'h000;
    bit          m_pend     = 1'b0;
    logic [6:0]  seg_tab[16];

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    end

    task automatic model_step(input bit r, input bit ld, input logic [11:0] d,
                              output logic [10:0] e);
        int slot;
        int c;
        bit fr;
        logic [3:0] digit;
        logic [2:0] an_v;
        logic [6:0] seg_v;
        if (!r) begin
            m_in_reset = 1'b1;
            m_p        = 0;
            m_pend     = 1'b0;
            m_shown    = 12'h000;
            e          = {1'b0, 3'b111, 7'h7F};
        end else begin
            m_p        = m_in_reset ? 0 : m_p + 1;
            m_in_reset = 1'b0;
            fr         = (m_p % FRAME) == 0;
            if (fr) begin
                if (ld) m_shown = d;
                else if (m_pend) m_shown = m_latest;
                m_pend = 1'b0;
            end else if (ld) begin
                m_latest = d;
                m_pend   = 1'b1;
            end
            slot  = (m_p / RD) % 3;
            c     = m_p % RD;
            an_v  = 3'b111;
            seg_v = 7'h7F;
            if (c >= GC) begin
                an_v[slot] = 1'b0;
                digit = 4'((m_shown >> (4 * slot)) & 12'hF);
                seg_v = seg_tab[digit];
`ifdef BCD_SCAN_LZB_EN
                if (slot == 2 && m_shown[11:8] == 4'd0) seg_v = 7'h7F;
                if (slot == 1 && m_shown[11:4] == 8'd0) seg_v = 7'h7F;
`endif
            end
            e = {fr, an_v, seg_v};
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit ld, input logic [11:0] d);
        logic [10:0] e;
        rst_n      = r;
        bus.load   = ld;
        bus.bcd_in = d;
        model_step(r, ld, d, e);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 12'h000);
    endtask

    // Idle until the next driven cycle sits at frame phase ph.
    task automatic run_to(input int ph);
        for (int i = 0; i < FRAME; i++) begin
            if ((((m_in_reset ? 0 : m_p + 1)) % FRAME) == ph) break;
            step(1'b1, 1'b0, 12'h000);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [10:0] e;
        logic [10:0] a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.frame_o, bus.an_n, bus.seg_n};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL scan_out t=%0t: got frame=%0b an_n=%03b seg_n=%02h, expected frame=%0b an_n=%03b seg_n=%02h",
                         $time, a[10], a[9:7], a[6:0], e[10], e[9:7], e[6:0]);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: stimulus did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          r;
        bit          ld;
        logic [11:0] d;
        bus.load   = 1'b0;
        bus.bcd_in = 12'h000;

        // reset, then load on the very first frame edge
        step(1'b0, 1'b0, 12'h000);
        step(1'b0, 1'b0, 12'h000);
        step(1'b1, 1'b1, 12'h255);
        idle(FRAME);

        // mid-frame load at idx=1; old value holds until the next frame
        run_to(RD);
        step(1'b1, 1'b1, 12'h198);
        idle(2 * FRAME);

        // zeros in the upper digits
        step(1'b1, 1'b1, 12'h007);
        idle(2 * FRAME);

        // non-decimal nibbles, loaded exactly on a frame boundary
        run_to(0);
        step(1'b1, 1'b1, 12'hA0F);
        idle(2 * FRAME);

        // two loads in one frame: last one wins
        run_to(2);
        step(1'b1, 1'b1, 12'h111);
        run_to(6);
        step(1'b1, 1'b1, 12'h222);
        idle(2 * FRAME);

        // pending value then reset mid-SHOW discards it
        run_to(3);
        step(1'b1, 1'b1, 12'h987);
        run_to(6);
        step(1'b0, 1'b0, 12'h000);
        idle(2 * FRAME);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) != 0);
            ld = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 1) == 1)
                d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                d = 12'($urandom_range(0, 4095));
            step(r, ld, d);
        end
        idle(FRAME);

        // drain
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected outputs left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
